// File: rtl/imem_upg_pkg.sv
// Shared types and constants for the instruction-memory upgrade controller.
package imem_upg_pkg;

  // Controller states: normal fetch, byte download, CPU reset release.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2
  } upg_state_e;

  // Byte position within a 32-bit word.
  localparam int IDX_W = 2;

  // Instruction presented to the fetch unit while the ROM is not readable.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/imem_upg_ctrl_packer.sv
// Little-endian byte-to-word packer for the UART download path.
// The fourth byte is not stored; the completed word is offered combinationally
// in the same cycle so the caller can latch it into its write register.
module upg_word_packer
  import imem_upg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_rdy_o,
  output logic        part_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [23:0]      asm_q, asm_d;

  assign idx_nxt    = byte_vld_i ? idx_q + 1'b1 : idx_q;
  assign word_rdy_o = byte_vld_i && (idx_q == LAST_IDX);
  assign word_o     = {byte_i, asm_q};
  // A partial word remains if, counting this cycle's byte, the index is not at a word boundary.
  assign part_o     = (idx_nxt != '0);

  // Next byte index and assembly bytes; clear wins over an incoming byte.
  always_comb begin
    idx_d = idx_nxt;
    asm_d = asm_q;
    if (byte_vld_i) begin
      case (idx_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: asm_d        = asm_q;
      endcase
    end
    if (clr_i) begin
      idx_d = '0;
      asm_d = '0;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_upg_ctrl.sv
// Instruction ROM port arbiter: CPU fetch in RUN, UART program download in LOAD,
// followed by a timed CPU reset release.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | fetch unit owns the ROM port, CPU out of reset
// ST_LOAD    | bytes packed into words and written to consecutive addresses
// ST_RELEASE | CPU held in reset while the release down-counter expires
module imem_upg_ctrl
  import imem_upg_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int ROM_DEPTH   = 16384,
  parameter int RELEASE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  output logic [31:0]       cpu_instr_o,
  input  logic              upg_en_i,
  input  logic              upg_byte_vld_i,
  input  logic [7:0]        upg_byte_i,
  input  logic              upg_done_i,
  output logic [ADDR_W-1:0] rom_adr_o,
  output logic [31:0]       rom_din_o,
  output logic              rom_we_o,
  input  logic [31:0]       rom_dout_i,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              err_o
);

  localparam int              REL_W   = (RELEASE_CYC < 2) ? 1 : $clog2(RELEASE_CYC + 1);
  localparam logic [REL_W-1:0] REL_C   = REL_W'(RELEASE_CYC);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(ROM_DEPTH);

  upg_state_e       state_q, state_d;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d, rel_dec;
  logic [ADDR_W:0]  wr_adr_q, wr_adr_d;
  logic [ADDR_W:0]  word_cnt_q, word_cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             wr_pend_q, wr_pend_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic             pk_clr, pk_vld, pk_rdy, pk_part;
  logic [31:0]      pk_word;

  upg_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pk_clr),
    .byte_vld_i (pk_vld),
    .byte_i     (upg_byte_i),
    .word_o     (pk_word),
    .word_rdy_o (pk_rdy),
    .part_o     (pk_part)
  );

  assign rel_dec = rel_cnt_q - 1'b1;

  // Next-state, address/count bookkeeping and packer control.
  always_comb begin
    state_d    = state_q;
    rel_cnt_d  = rel_cnt_q;
    wr_adr_d   = wr_adr_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    wr_pend_d  = 1'b0;
    wr_data_d  = wr_data_q;
    pk_clr     = 1'b0;
    pk_vld     = 1'b0;

    // A write issued this cycle advances the address; may land in LOAD or RELEASE.
    if (wr_pend_q) begin
      wr_adr_d = wr_adr_q + 1'b1;
      if (word_cnt_q != DEPTH_C) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (upg_en_i) begin
          state_d    = ST_LOAD;
          wr_adr_d   = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
          pk_clr     = 1'b1;
        end
      end

      ST_LOAD: begin
        pk_vld = upg_byte_vld_i && !ovf_q;
        if (pk_rdy) begin
          if (wr_adr_q == DEPTH_C) begin
            err_d = 1'b1;
            ovf_d = 1'b1;
          end else begin
            wr_pend_d = 1'b1;
            wr_data_d = pk_word;
          end
        end
        if (upg_done_i || !upg_en_i) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = REL_C;
          pk_clr    = 1'b1;
          if (pk_part) begin
            err_d = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        rel_cnt_d = rel_dec;
        if (rel_dec == '0) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d   = ST_RELEASE;
        rel_cnt_d = REL_C;
      end
    endcase
  end

  // Controller registers; reset parks the CPU in the release sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RELEASE;
      rel_cnt_q  <= REL_C;
      wr_adr_q   <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rel_cnt_q  <= rel_cnt_d;
      wr_adr_q   <= wr_adr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // ROM port and CPU-facing output muxing.
  always_comb begin
    rom_we_o    = wr_pend_q;
    rom_din_o   = wr_data_q;
    cpu_rst_o   = (state_q != ST_RUN);
    busy_o      = (state_q == ST_LOAD);
    word_cnt_o  = word_cnt_q;
    err_o       = err_q;
    cpu_instr_o = (state_q == ST_RUN) ? rom_dout_i : NOP_INSTR;
    if (wr_pend_q || (state_q == ST_LOAD)) begin
      rom_adr_o = wr_adr_q[ADDR_W-1:0];
    end else begin
      rom_adr_o = cpu_adr_i;
    end
  end

endmodule

// File: tb/tb_imem_upg_ctrl.sv
// Randomised self-checking bench for imem_upg_ctrl with a small ROM so overflow is reachable.
module tb_imem_upg_ctrl;

  localparam int ADDR_W      = 14;
  localparam int ROM_DEPTH   = 4;
  localparam int RELEASE_CYC = 4;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    int                cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] cpu_adr_i = '0;
  logic [31:0]       cpu_instr_o;
  logic              upg_en_i = 1'b0;
  logic              upg_byte_vld_i = 1'b0;
  logic [7:0]        upg_byte_i = '0;
  logic              upg_done_i = 1'b0;
  logic [ADDR_W-1:0] rom_adr_o;
  logic [31:0]       rom_din_o;
  logic              rom_we_o;
  logic [31:0]       rom_dout_i = '0;
  logic              cpu_rst_o;
  logic              busy_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              err_o;

  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc   = 0;
  wr_t obs_q[$];

  always #5 clk = ~clk;

  imem_upg_ctrl #(
    .ADDR_W      (ADDR_W),
    .ROM_DEPTH   (ROM_DEPTH),
    .RELEASE_CYC (RELEASE_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_adr_i      (cpu_adr_i),
    .cpu_instr_o    (cpu_instr_o),
    .upg_en_i       (upg_en_i),
    .upg_byte_vld_i (upg_byte_vld_i),
    .upg_byte_i     (upg_byte_i),
    .upg_done_i     (upg_done_i),
    .rom_adr_o      (rom_adr_o),
    .rom_din_o      (rom_din_o),
    .rom_we_o       (rom_we_o),
    .rom_dout_i     (rom_dout_i),
    .cpu_rst_o      (cpu_rst_o),
    .busy_o         (busy_o),
    .word_cnt_o     (word_cnt_o),
    .err_o          (err_o)
  );

  always @(posedge clk) cyc = cyc + 1;

  // Record every ROM write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (rom_we_o) obs_q.push_back('{rom_adr_o, rom_din_o, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a negedge in the first release cycle; ends at the first RUN negedge.
  task automatic check_release(input int n_high);
    for (int i = 0; i < n_high; i++) begin
      check_val("rel_cpu_rst", cpu_rst_o, 1);
      check_val("rel_busy", busy_o, 0);
      @(negedge clk);
    end
    check_val("run_cpu_rst", cpu_rst_o, 0);
    check_val("run_rom_adr", rom_adr_o, cpu_adr_i);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_adr_i  = ADDR_W'($urandom);
      rom_dout_i = $urandom;
      #1;
      check_val("idle_rom_adr", rom_adr_o, cpu_adr_i);
      check_val("idle_instr", cpu_instr_o, rom_dout_i);
      check_val("idle_we", rom_we_o, 0);
      check_val("idle_cpu_rst", cpu_rst_o, 0);
    end
  endtask

  // term: 0 = done strobe after last byte, 1 = done with last byte, 2 = enable dropped.
  task automatic do_load(input bytes_t bq, input bit b2b, input int term);
    int          bcyc[$];
    int          n, nw, nexp;
    bit          coinc, exp_err;
    logic [31:0] w;
    n    = bq.size();
    nw   = n / 4;
    nexp = (nw > ROM_DEPTH) ? ROM_DEPTH : nw;
    exp_err = ((n % 4) != 0) || (nw > ROM_DEPTH);
    obs_q.delete();
    upg_en_i = 1'b1;
    @(negedge clk);
    check_val("load_busy", busy_o, 1);
    check_val("load_cpu_rst", cpu_rst_o, 1);
    check_val("load_nop", cpu_instr_o, 0);
    for (int i = 0; i < n; i++) begin
      coinc = (term == 1) && (i == n - 1);
      if (!b2b) repeat ($urandom_range(2, 0)) @(negedge clk);
      upg_byte_vld_i = 1'b1;
      upg_byte_i     = bq[i];
      upg_done_i     = coinc;
      bcyc.push_back(cyc);
      @(negedge clk);
      upg_byte_vld_i = 1'b0;
      upg_done_i     = 1'b0;
      if (!coinc) check_val("load_busy_b", busy_o, 1);
    end
    if (!(term == 1 && n > 0)) begin
      if (term == 2) upg_en_i = 1'b0;
      else upg_done_i = 1'b1;
      @(negedge clk);
      upg_done_i = 1'b0;
    end
    check_release(RELEASE_CYC);
    upg_en_i = 1'b0;
    check_val("word_cnt", word_cnt_o, nexp);
    check_val("err", err_o, exp_err);
    check_val("wr_count", obs_q.size(), nexp);
    for (int k = 0; k < nexp && k < obs_q.size(); k++) begin
      w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
      check_val("wr_adr", obs_q[k].adr, k);
      check_val("wr_dat", obs_q[k].dat, w);
      check_val("wr_cyc", obs_q[k].cyc, bcyc[4*k+3] + 1);
    end
  endtask

  task automatic reset_mid_load(input int nb);
    obs_q.delete();
    upg_en_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      upg_byte_vld_i = 1'b1;
      upg_byte_i     = 8'($urandom_range(255, 0));
      @(negedge clk);
      upg_byte_vld_i = 1'b0;
    end
    check_val("pre_rst_word_cnt", word_cnt_o, nb / 4);
    rst = 1'b1;
    #1;
    check_val("mid_rst_cpu_rst", cpu_rst_o, 1);
    check_val("mid_rst_busy", busy_o, 0);
    check_val("mid_rst_word_cnt", word_cnt_o, 0);
    check_val("mid_rst_err", err_o, 0);
    check_val("mid_rst_we", rom_we_o, 0);
    @(negedge clk);
    rst       = 1'b0;
    upg_en_i  = 1'b0;
    cpu_adr_i = 14'h0005;
    check_release(RELEASE_CYC);
    check_val("mid_rst_wr_count", obs_q.size(), nb / 4);
  endtask

  bytes_t bq;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_rst", cpu_rst_o, 1);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_we", rom_we_o, 0);
    check_val("rst_din", rom_din_o, 0);
    check_val("rst_word_cnt", word_cnt_o, 0);
    check_val("rst_err", err_o, 0);
    cpu_adr_i = 14'h0005;
    rst = 1'b0;
    check_release(RELEASE_CYC);
    check_val("run_adr_5", rom_adr_o, 14'h0005);
    run_idle(4);

    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(bq, 1'b1, 0);
    run_idle(2);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(bq, 1'b1, 0);
    run_idle(2);

    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'(i * 13 + 7));
    do_load(bq, 1'b1, 2);
    run_idle(2);

    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(bq, 1'b1, 1);
    run_idle(2);

    reset_mid_load(2);
    run_idle(2);
    reset_mid_load(6);
    run_idle(2);

    for (int it = 0; it < 25; it++) begin
      int nb, term;
      bit b2b;
      nb   = $urandom_range(22, 0);
      b2b  = 1'($urandom_range(1, 0));
      term = $urandom_range(2, 0);
      if (term == 1 && (nb == 0 || (nb % 4) != 0)) term = 0;
      bq.delete();
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom_range(255, 0)));
      do_load(bq, b2b, term);
      run_idle($urandom_range(3, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
